// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and baud-accumulator sizing.
// Used by uart_frame_tx and intended for reuse by uart_rx.
package uart_pkg;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

  typedef logic [1:0] uart_parity_t;

  localparam uart_parity_t PAR_NONE = 2'd0;
  localparam uart_parity_t PAR_ODD  = 2'd1;
  localparam uart_parity_t PAR_EVEN = 2'd2;

  // The accumulator must hold values up to 2*CLK_FREQ-1 before the wrap subtraction.
  function automatic int uart_baud_acc_width(input int clk_freq);
    return $clog2(clk_freq) + 1;
  endfunction

  function automatic logic uart_parity_bit(input logic [7:0] data, input uart_parity_t mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// 8-bit synchronous FIFO, depth 2^EA (EA=0 is a single holding register).
// Flags are registered: not_full is low during reset and rises on the first edge after it.
module uart_sync_fifo #(
  parameter int EA = 2
) (
  input  logic       rstn,
  input  logic       clk,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       not_full
);

  localparam int DEPTH = 1 << EA;
  localparam int PW    = (EA > 0) ? EA : 1;
  localparam logic [EA:0] FULL_COUNT = DEPTH[EA:0];

  logic [7:0]    mem [1 << PW];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [EA:0]   count;
  logic [EA:0]   count_next;
  logic          wr_fire;
  logic          rd_fire;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (EA == 0) ? '0 : p + 1'b1;
  endfunction

  assign wr_fire = wr_en & not_full;
  assign rd_fire = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    count_next = count;
    if (wr_fire && !rd_fire) begin
      count_next = count + 1'b1;
    end else if (rd_fire && !wr_fire) begin
      count_next = count - 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and flags alone define validity.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      not_full <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_fire) rd_ptr <= ptr_inc(rd_ptr);
      count    <= count_next;
      empty    <= (count_next == '0);
      not_full <= (count_next != FULL_COUNT);
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Byte-stream to UART serializer: FIFO-buffered bytes shifted out as start/8N/parity/stop frames.
// Bit timing comes from a fractional accumulator restarted at every start bit.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int    CLK_FREQ  = 27000000,
  parameter int    BAUD_RATE = 115200,
  parameter string PARITY    = "NONE",
  parameter int    STOP_BITS = 1,
  parameter int    FIFO_EA   = 2
) (
  input  logic       rstn,
  input  logic       clk,
  output logic       i_tready,
  input  logic       i_tvalid,
  input  logic [7:0] i_tdata,
  output logic       o_uart_tx
);

  localparam int AW = uart_baud_acc_width(CLK_FREQ);
  localparam logic [AW-1:0] CLK_W  = AW'(CLK_FREQ);
  localparam logic [AW-1:0] BAUD_W = AW'(BAUD_RATE);
  localparam uart_parity_t  PAR_MODE =
    (PARITY == "ODD") ? PAR_ODD : (PARITY == "EVEN") ? PAR_EVEN : PAR_NONE;
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_t   state;
  logic [AW-1:0] acc;
  logic [AW-1:0] acc_sum;
  logic          tick;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic          par_bit;
  logic          pop;
  logic          line_bit;
  logic [7:0]    fifo_rd_data;
  logic          fifo_empty;

  uart_sync_fifo #(
    .EA(FIFO_EA)
  ) u_fifo (
    .rstn     (rstn),
    .clk      (clk),
    .wr_en    (i_tvalid),
    .wr_data  (i_tdata),
    .rd_en    (pop),
    .rd_data  (fifo_rd_data),
    .empty    (fifo_empty),
    .not_full (i_tready)
  );

  always_comb begin
    acc_sum = acc + BAUD_W;
    tick    = (acc_sum >= CLK_W);
  end

  // A frame starts from IDLE, or straight out of the last stop bit so frames abut.
  always_comb begin
    pop = 1'b0;
    case (state)
      ST_IDLE: pop = ~fifo_empty;
      ST_STOP: pop = tick && (bit_cnt == LAST_STOP) && ~fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  always_comb begin
    line_bit = 1'b1;
    case (state)
      ST_START:  line_bit = 1'b0;
      ST_DATA:   line_bit = shift[0];
      ST_PARITY: line_bit = par_bit;
      default:   line_bit = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      acc       <= '0;
      shift     <= '0;
      bit_cnt   <= '0;
      par_bit   <= 1'b0;
      o_uart_tx <= 1'b1;
    end else begin
      o_uart_tx <= line_bit;

      if (pop) begin
        acc <= '0;
      end else if (tick) begin
        acc <= acc_sum - CLK_W;
      end else begin
        acc <= acc_sum;
      end

      if (pop) begin
        state   <= ST_START;
        shift   <= fifo_rd_data;
        par_bit <= uart_parity_bit(fifo_rd_data, PAR_MODE);
        bit_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_START: if (tick) state <= ST_DATA;
          ST_DATA: begin
            if (tick) begin
              shift <= {1'b0, shift[7:1]};
              if (bit_cnt == 3'd7) begin
                bit_cnt <= '0;
                state   <= (PAR_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          ST_PARITY: if (tick) state <= ST_STOP;
          ST_STOP: begin
            if (tick) begin
              if (bit_cnt == LAST_STOP) begin
                bit_cnt <= '0;
                state   <= ST_IDLE;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench for uart_frame_tx: three configurations, per-cycle frame shape checking.
`timescale 1ns/1ps
module tb_uart_frame_tx;

  localparam int N = 3;
  localparam int CF [N] = '{27000000, 1000, 1000};
  localparam int BR [N] = '{115200, 240, 240};
  localparam int PM [N] = '{0, 1, 2};  // 0 none, 1 odd, 2 even
  localparam int SB [N] = '{1, 2, 1};
  localparam int HS_BOUND = 10000;

  typedef struct {
    logic [7:0] data;
    int         par;      // hand-computed parity bit, -1 when not checked
    bit         chk_lat;
    longint     start;
    bit         b2b;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn   [N];
  logic       tvalid [N];
  logic [7:0] tdata  [N];
  logic       tready [N];
  logic       line   [N];
  longint     cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  bit         mon_stop = 1'b0;
  bit         mon_busy [N];
  exp_t       q0[$];
  exp_t       q1[$];
  exp_t       q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_frame_tx #(.CLK_FREQ(CF[0]), .BAUD_RATE(BR[0]), .PARITY("NONE"), .STOP_BITS(SB[0]), .FIFO_EA(2)) dut_a (
    .rstn(rstn[0]), .clk(clk), .i_tready(tready[0]), .i_tvalid(tvalid[0]), .i_tdata(tdata[0]), .o_uart_tx(line[0]));
  uart_frame_tx #(.CLK_FREQ(CF[1]), .BAUD_RATE(BR[1]), .PARITY("ODD"), .STOP_BITS(SB[1]), .FIFO_EA(0)) dut_b (
    .rstn(rstn[1]), .clk(clk), .i_tready(tready[1]), .i_tvalid(tvalid[1]), .i_tdata(tdata[1]), .o_uart_tx(line[1]));
  uart_frame_tx #(.CLK_FREQ(CF[2]), .BAUD_RATE(BR[2]), .PARITY("EVEN"), .STOP_BITS(SB[2]), .FIFO_EA(1)) dut_c (
    .rstn(rstn[2]), .clk(clk), .i_tready(tready[2]), .i_tvalid(tvalid[2]), .i_tdata(tdata[2]), .o_uart_tx(line[2]));

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic int q_size(input int idx);
    case (idx)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic q_push(input int idx, input exp_t e);
    case (idx)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic exp_t q_pop(input int idx);
    case (idx)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic q_clear(input int idx);
    case (idx)
      0: q0.delete();
      1: q1.delete();
      default: q2.delete();
    endcase
  endtask

  // Cycle (from the start bit) at which bit j of a frame begins.
  function automatic longint bnd(input int idx, input longint j);
    return (j * CF[idx] + BR[idx] - 1) / BR[idx];
  endfunction

  task automatic monitor(input int idx);
    longint prev_end = -100;
    while (!mon_stop) begin
      @(negedge clk);
      if (rstn[idx] === 1'b1 && line[idx] === 1'b0) begin : frame
        exp_t       e;
        logic       expb [16];
        logic [7:0] got;
        logic       gp;
        longint     c0;
        longint     len;
        int         k;
        int         j;
        int         bad;
        bit         abort;
        mon_busy[idx] = 1'b1;
        c0 = cyc;
        check($sformatf("frame_expected[%0d]", idx), q_size(idx) > 0, 1'b1);
        if (q_size(idx) > 0) begin
          e = q_pop(idx);
          k = 0;
          expb[k] = 1'b0; k++;
          for (int i = 0; i < 8; i++) begin expb[k] = e.data[i]; k++; end
          if (PM[idx] != 0) begin
            expb[k] = (PM[idx] == 1) ? ~^e.data : ^e.data; k++;
          end
          for (int i = 0; i < SB[idx]; i++) begin expb[k] = 1'b1; k++; end
          len = bnd(idx, k);
          j = 0; bad = 0; got = '0; gp = 1'bx; abort = 1'b0;
          for (longint t = 0; t < len; t++) begin
            if (t > 0) @(negedge clk);
            if (rstn[idx] !== 1'b1) begin abort = 1'b1; break; end
            while (bnd(idx, j + 1) <= t) j++;
            if (line[idx] !== expb[j]) bad++;
            if (t == (bnd(idx, j) + bnd(idx, j + 1)) / 2) begin
              if (j >= 1 && j <= 8) got[j-1] = line[idx];
              if (j == 9 && PM[idx] != 0) gp = line[idx];
            end
          end
          if (!abort) begin
            check($sformatf("data[%0d]", idx), got, e.data);
            check($sformatf("shape_bad_cycles[%0d] byte 0x%0h", idx, e.data), bad, 0);
            if (e.par >= 0) check($sformatf("parity[%0d] byte 0x%0h", idx, e.data), gp, e.par[0]);
            if (e.chk_lat) check($sformatf("start_cycle[%0d]", idx), c0, e.start);
            if (e.b2b) check($sformatf("b2b_gap[%0d]", idx), c0 - prev_end, 0);
            prev_end = c0 + len;
          end else begin
            while (rstn[idx] !== 1'b1) @(negedge clk);
            prev_end = -100;
          end
        end else begin
          while (line[idx] === 1'b0) @(negedge clk);
        end
        mon_busy[idx] = 1'b0;
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input int idx, input logic [7:0] d, input int par,
                      input bit chk_lat, input bit b2b, output int waited);
    exp_t e;
    tvalid[idx] = 1'b1;
    tdata[idx]  = d;
    waited = 0;
    while (tready[idx] !== 1'b1 && waited < HS_BOUND) begin
      @(negedge clk);
      waited++;
    end
    check($sformatf("handshake[%0d] 0x%0h", idx, d), waited < HS_BOUND, 1'b1);
    e.data = d; e.par = par; e.chk_lat = chk_lat; e.start = cyc + 3; e.b2b = b2b;
    if (waited < HS_BOUND) q_push(idx, e);
    @(negedge clk);
  endtask

  task automatic wait_idle(input int idx);
    int n = 0;
    while ((q_size(idx) != 0 || mon_busy[idx]) && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("drain[%0d]", idx), n < 30000, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int w;
    int ws [6];
    int first_stall;
    int low_cnt;
    logic [7:0] burst [6];
    burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66, 8'h77};

    for (int i = 0; i < N; i++) begin
      rstn[i] = 1'b0; tvalid[i] = 1'b0; tdata[i] = 8'h00; mon_busy[i] = 1'b0;
    end
    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none

    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset_line[%0d]", i), line[i], 1'b1);
      check($sformatf("reset_tready[%0d]", i), tready[i], 1'b0);
      rstn[i] = 1'b1;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) check($sformatf("tready_after_reset[%0d]", i), tready[i], 1'b1);

    // Parity frames: ODD/2-stop and EVEN/1-stop.
    send(1, 8'h41, 1, 1'b1, 1'b0, w); tvalid[1] = 1'b0; wait_idle(1);
    send(1, 8'h00, 1, 1'b1, 1'b0, w); tvalid[1] = 1'b0; wait_idle(1);
    send(2, 8'h41, 0, 1'b1, 1'b0, w); tvalid[2] = 1'b0; wait_idle(2);
    send(2, 8'hFE, 1, 1'b1, 1'b0, w); tvalid[2] = 1'b0; wait_idle(2);

    // Held-valid stream on the 2-stop, single-register instance: frames must abut.
    send(1, 8'h00, 1, 1'b1, 1'b0, w);
    send(1, 8'hFF, 1, 1'b0, 1'b1, w);
    send(1, 8'hA5, 1, 1'b0, 1'b1, w);
    tvalid[1] = 1'b0;
    wait_idle(1);

    // 8N1 single byte.
    send(0, 8'h55, -1, 1'b1, 1'b0, w); tvalid[0] = 1'b0; wait_idle(0);

    // Six bytes into a 4-deep FIFO with valid held high.
    for (int i = 0; i < 6; i++) send(0, burst[i], -1, i == 0, i > 0, ws[i]);
    tvalid[0] = 1'b0;
    first_stall = 6;
    for (int i = 5; i >= 0; i--) if (ws[i] > 0) first_stall = i;
    check("first_stalled_byte", first_stall, 5);
    wait_idle(0);

    // Reset in the middle of the data field with two bytes queued.
    send(0, 8'h3C, -1, 1'b1, 1'b0, w);
    send(0, 8'hA1, -1, 1'b0, 1'b1, w);
    send(0, 8'hB2, -1, 1'b0, 1'b1, w);
    tvalid[0] = 1'b0;
    repeat (600) @(negedge clk);
    #2 rstn[0] = 1'b0;
    #1;
    check("midframe_reset_line", line[0], 1'b1);
    check("midframe_reset_tready", tready[0], 1'b0);
    q_clear(0);
    repeat (3) @(negedge clk);
    rstn[0] = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < 7200; i++) begin
      @(negedge clk);
      if (line[0] !== 1'b1) low_cnt++;
    end
    check("post_reset_quiet_low_cycles", low_cnt, 0);
    send(0, 8'hC3, -1, 1'b1, 1'b0, w); tvalid[0] = 1'b0; wait_idle(0);

    mon_stop = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < N; i++) check($sformatf("leftover[%0d]", i), q_size(i), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
